dram_responder: RTL and testbench
=================================

// Module: dram_responder
// PURPOSE
//  Slave-side endpoint of the DRAM request/response FIFO link. Pops cache-line
//  requests from the request FIFO, which runs in first-word fall-through mode.
//  Serialises each line into MEM_W-bit beats on a fixed-latency memory port.
//  For reads, gathers the returned beats into a line and pushes it into the
//  response FIFO. Runs in the slave clock domain.
// PARAMETERS
//  ADDR_W   27   line address width
//  LINE_W   128  cache-line width; must be a multiple of MEM_W
//  MEM_W    32   memory data width; BEATS = LINE_W/MEM_W (default 4)
//  MEM_LAT  2    memory read latency in cycles, >= 1
// PORTS
//  clk        in   1                 slave-domain clock
//  rst        in   1                 asynchronous reset, active-high
//  req        in   1+ADDR_W+LINE_W   {we, addr, wdata}; FWFT head of the request FIFO
//  req_en     in   1                 request FIFO not empty
//  req_rdy    out  1                 pops the request FIFO (rd_en)
//  rsp        out  LINE_W            response line to the response FIFO
//  rsp_en     out  1                 response FIFO write enable
//  rsp_rdy    in   1                 response FIFO not full
//  mem_en     out  1                 memory access strobe
//  mem_we     out  1                 1 = write, 0 = read
//  mem_addr   out  ADDR_W+log2(BEATS) {line addr, beat idx}
//  mem_wdata  out  MEM_W             write beat
//  mem_rdata  in   MEM_W             read beat, valid MEM_LAT cycles after the sampling edge
// BEHAVIOUR
//  Reset values: state IDLE, req_rdy=1 (IDLE), rsp_en=0, rsp=0, mem_en=0,
//   mem_we=0, beat counters=0, latency pipe cleared.
//  FSM IDLE -> WR | RD_ISSUE -> RD_WAIT -> RSP -> IDLE.
//  IDLE: req_rdy = (state==IDLE), combinational. req_en&&req_rdy at edge E0
//   latches req and pops it. we=1 -> WR; we=0 -> RD_ISSUE. No accept in any other state.
//  Beat order: beat i = line[i*MEM_W +: MEM_W] at mem_addr {addr,i}, i=0..BEATS-1.
//  WR: mem_en=mem_we=1 for cycles 1..BEATS, one beat per cycle, no stalls.
//   Returns to IDLE at edge E(BEATS); no response pushed (see CONFIGURATION).
//  RD_ISSUE: mem_en=1, mem_we=0 for cycles 1..BEATS. A MEM_LAT-deep valid pipe
//   tags every issued beat. After the last issue -> RD_WAIT.
//  RD_WAIT: each tagged return is written into its beat slot of the rsp line.
//   The last beat is captured at edge E(BEATS+MEM_LAT); rsp_en=1 from that edge,
//   i.e. from cycle 7 with default parameters -> RSP.
//  RSP: rsp_en and rsp stay stable until rsp_en&&rsp_rdy. On that edge rsp_en
//   drops and the FSM returns to IDLE. Back-to-back gap: req_rdy returns 1 cycle after push.
//  rsp_rdy=0 when entering RSP: the block holds indefinitely, no data loss.
//  req_en arriving while busy: ignored, the request stays at the FIFO head.
//  Reset mid-operation: FSM -> IDLE and the valid pipe clears. Memory returns in
//   flight are discarded; a partially written line stays partially written.
//  The beat counter saturates at BEATS-1; no wrap beyond a line.
// CONFIGURATION
//  DRAM_RESPONDER_WRITE_ACK_EN defined: WR goes to RSP instead of IDLE and
//   pushes rsp='0 with rsp_en=1 from edge E(BEATS), same hold rules as reads.
//  Undefined: writes are posted; the response stream carries read data only.
// STRUCTURE
//  Package dram_pkg: ADDR_W/LINE_W/MEM_W localparams,
//   typedef struct packed {logic we; logic [ADDR_W-1:0] addr;
//   logic [LINE_W-1:0] data;} dram_req_t; typedef logic [LINE_W-1:0] dram_rsp_t;
//   FSM state enum.
//  Sub-module dram_rd_collect: latency valid pipe, beat index and line
//   assembly; reports the done pulse to the FSM.
// TESTING
//  1 Read: we=0 addr=0x10, mem preloaded 0xA0..0xA3 -> beats at mem_addr 0x40..0x43,
//    rsp=0x000000A3_000000A2_000000A1_000000A0, rsp_en from cycle 7.
//  2 Write: we=1 addr=0x2 data=0x44..11_33..22.. -> 4 write beats to 0x8..0xB, back in
//    IDLE at edge 4, no rsp_en (macro undefined); rsp=0 push when defined.
//  3 Backpressure: rsp_rdy=0 for 20 cycles during a read -> rsp_en held, rsp stable,
//    req_rdy=0 throughout; single push once rsp_rdy=1.
//  4 Back-to-back: 3 reads queued at the FIFO head -> each popped once, in order,
//    responses in order with correct data; no duplicate or skipped pops.
//  5 Reset at cycle 3 of a read -> all outputs at reset values. A later read of
//    addr 0x10 returns clean data, with no stale beats mixed in.
//  6 MEM_LAT=1 and MEM_LAT=4 builds: scenario 1 passes with rsp_en at E(BEATS+MEM_LAT).

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and widths for the DRAM responder.
// Line, address and memory-beat widths are fixed here for the whole build.
package dram_pkg;

  localparam int ADDR_W = 27;
  localparam int LINE_W = 128;
  localparam int MEM_W  = 32;
  localparam int BEATS  = LINE_W / MEM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } dram_req_t;

  typedef logic [LINE_W-1:0] dram_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RSP
  } dram_state_t;

endpackage

// File: rtl/dram_rd_collect.sv
// Read-return collector: tags each issued read beat through a MEM_LAT-deep
// valid pipe, drops the returning beats into their slots of the line and
// flags the capture of the final beat.
module dram_rd_collect
  import dram_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_issue,
  input  logic [MEM_W-1:0]  i_rdata,
  output logic [LINE_W-1:0] o_line,
  output logic              o_done
);

  logic [MEM_LAT-1:0] r_vld;
  logic [BEAT_W-1:0]  r_idx;
  logic [LINE_W-1:0]  r_line;
  logic               w_cap;

  assign w_cap  = r_vld[MEM_LAT-1];
  assign o_done = w_cap && (r_idx == BEAT_W'(BEATS - 1));
  assign o_line = r_line;

  // Valid pipe: a beat issued at edge Ei is captured at edge E(i+MEM_LAT).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_issue;
      for (int k = 1; k < MEM_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  // Return beat index: restarts per line, saturates on the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (w_cap && (r_idx != BEAT_W'(BEATS - 1))) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Line assembly: every tagged return overwrites its own beat slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
    end else if (w_cap) begin
      r_line[int'(r_idx)*MEM_W +: MEM_W] <= i_rdata;
    end
  end

endmodule

// File: rtl/dram_responder.sv
// DRAM link slave endpoint: pops line requests from an FWFT request FIFO,
// serialises them into memory beats and returns read lines to the response
// FIFO. Optional feature macro: DRAM_RESPONDER_WRITE_ACK_EN (when defined,
// writes also push an all-zero response line; otherwise writes are posted).
module dram_responder
  import dram_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1+ADDR_W+LINE_W-1:0] req,
  input  logic                     req_en,
  output logic                     req_rdy,
  output logic [LINE_W-1:0]        rsp,
  output logic                     rsp_en,
  input  logic                     rsp_rdy,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W+BEAT_W-1:0] mem_addr,
  output logic [MEM_W-1:0]         mem_wdata,
  input  logic [MEM_W-1:0]         mem_rdata
);

  dram_state_t       r_state;
  dram_state_t       w_state_nxt;
  dram_req_t         w_req;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_data;
  logic [BEAT_W-1:0] r_beat;
  logic              w_accept;
  logic              w_last;
  logic              w_issue;
  logic              w_rd_start;
  logic              w_done;
  dram_rsp_t         w_line;

  assign w_req      = req;
  assign w_last     = (r_beat == BEAT_W'(BEATS - 1));
  assign w_issue    = (r_state == ST_RD_ISSUE);
  assign w_rd_start = w_accept && !w_req.we;

  assign mem_addr  = {r_addr, r_beat};
  assign mem_wdata = r_data[int'(r_beat)*MEM_W +: MEM_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and control outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req_rdy     = 1'b0;
    rsp_en      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (req_en) begin
          w_accept    = 1'b1;
          w_state_nxt = w_req.we ? ST_WR : ST_RD_ISSUE;
        end
      end
      ST_WR: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        if (w_last) begin
`ifdef DRAM_RESPONDER_WRITE_ACK_EN
          w_state_nxt = ST_RSP;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      ST_RD_ISSUE: begin
        mem_en = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (w_done) begin
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_en = 1'b1;
        if (rsp_rdy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Issue beat counter: one beat per cycle, held at the last beat afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
    end else if (w_accept) begin
      r_beat <= '0;
    end else if ((r_state == ST_WR || r_state == ST_RD_ISSUE) && !w_last) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  // Request payload latch on pop.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= w_req.addr;
      r_data <= w_req.data;
    end
  end

`ifdef DRAM_RESPONDER_WRITE_ACK_EN
  logic r_we;

  // Remembers whether the pending response acknowledges a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we <= 1'b0;
    end else if (w_accept) begin
      r_we <= w_req.we;
    end
  end

  assign rsp = r_we ? '0 : w_line;
`else
  assign rsp = w_line;
`endif

  dram_rd_collect #(
    .MEM_LAT (MEM_LAT)
  ) u_collect (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_rd_start),
    .i_issue (w_issue),
    .i_rdata (mem_rdata),
    .o_line  (w_line),
    .o_done  (w_done)
  );

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: FWFT request FIFO model, fixed-latency
// memory model (read beat = address + 0x60), response logger.
module tb_dram_responder;
  import dram_pkg::*;

  parameter int MEM_LAT = 2;

  localparam int RW  = 1 + ADDR_W + LINE_W;
  localparam int MAW = ADDR_W + BEAT_W;

  localparam logic [LINE_W-1:0] L10 = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [LINE_W-1:0] L11 = 128'h000000A7_000000A6_000000A5_000000A4;
  localparam logic [LINE_W-1:0] L12 = 128'h000000AB_000000AA_000000A9_000000A8;
  localparam logic [LINE_W-1:0] WDAT = 128'h44444444_33333333_22222222_11111111;

  logic              clk = 1'b0;
  logic              rst;
  logic [RW-1:0]     req;
  logic              req_en;
  logic              req_rdy;
  logic [LINE_W-1:0] rsp;
  logic              rsp_en;
  logic              rsp_rdy;
  logic              mem_en;
  logic              mem_we;
  logic [MAW-1:0]    mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;

  logic [RW-1:0]     fifo[$];
  logic [LINE_W-1:0] rsp_log[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [MEM_W-1:0] r_rp [MEM_LAT];

  always #5 clk = ~clk;

  dram_responder #(.MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_en    (req_en),
    .req_rdy   (req_rdy),
    .rsp       (rsp),
    .rsp_en    (rsp_en),
    .rsp_rdy   (rsp_rdy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Fixed-latency memory: non-read cycles return a poison word.
  always @(posedge clk) begin
    r_rp[0] <= (mem_en && !mem_we) ? (32'(mem_addr) + 32'h60) : 32'hDEADBEEF;
    for (int k = 1; k < MEM_LAT; k++) r_rp[k] <= r_rp[k-1];
  end
  assign mem_rdata = r_rp[MEM_LAT-1];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic we, input logic [ADDR_W-1:0] a,
                                       input logic [LINE_W-1:0] d);
    return {we, a, d};
  endfunction

  task automatic drive_head();
    if (fifo.size() > 0) begin
      req_en = 1'b1;
      req    = fifo[0];
    end else begin
      req_en = 1'b0;
      req    = '0;
    end
  endtask

  // One clock: record pop/push handshakes seen before the edge.
  task automatic step();
    logic pop;
    pop = req_en && req_rdy;
    if (rsp_en && rsp_rdy) rsp_log.push_back(rsp);
    @(posedge clk);
    #1;
    if (pop) begin
      n_pop++;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    drive_head();
  endtask

  task automatic chk_reset_outs(input string tg);
    chk({tg, "_req_rdy"}, req_rdy, 1);
    chk({tg, "_rsp_en"},  rsp_en, 0);
    chk({tg, "_rsp"},     rsp, 0);
    chk({tg, "_mem_en"},  mem_en, 0);
    chk({tg, "_mem_we"},  mem_we, 0);
  endtask

  task automatic run_read(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] exp,
                          input string tg);
    int c;
    int p0;
    fifo.push_back(mk(1'b0, a, '0));
    drive_head();
    chk({tg, "_rdy0"}, req_rdy, 1);
    p0 = n_pop;
    step();
    chk({tg, "_pop"}, n_pop - p0, 1);
    for (int k = 0; k < BEATS; k++) begin
      chk({tg, "_men"},  mem_en, 1);
      chk({tg, "_mwe"},  mem_we, 0);
      chk({tg, "_madr"}, mem_addr, {a, BEAT_W'(k)});
      chk({tg, "_busy"}, req_rdy, 0);
      step();
    end
    c = BEATS + 1;
    while (!rsp_en && c < 40) begin
      step();
      c++;
    end
    chk({tg, "_lat"},  c, BEATS + MEM_LAT + 1);
    chk({tg, "_data"}, rsp, exp);
    p0 = rsp_log.size();
    step();
    chk({tg, "_push"},    rsp_log.size() - p0, 1);
    if (rsp_log.size() > 0) chk({tg, "_logd"}, rsp_log[rsp_log.size()-1], exp);
    chk({tg, "_rsp_off"}, rsp_en, 0);
    chk({tg, "_rdy_back"}, req_rdy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int p0;
    int p1;
    int pb;
    rst     = 1'b1;
    req     = '0;
    req_en  = 1'b0;
    rsp_rdy = 1'b1;
    step();
    step();
    chk_reset_outs("rst0");
    rst = 1'b0;
    step();

    // 1: single read
    run_read(27'h10, L10, "rd1");

    // 2: single write
    fifo.push_back(mk(1'b1, 27'h2, WDAT));
    drive_head();
    step();
    for (int k = 0; k < BEATS; k++) begin
      logic [LINE_W-1:0] wd;
      wd = WDAT;
      chk("wr_men",  mem_en, 1);
      chk("wr_mwe",  mem_we, 1);
      chk("wr_madr", mem_addr, 29'h8 + 29'(k));
      chk("wr_wdat", mem_wdata, wd[k*MEM_W +: MEM_W]);
      chk("wr_busy", req_rdy, 0);
      step();
    end
    chk("wr_men_off", mem_en, 0);
`ifdef DRAM_RESPONDER_WRITE_ACK_EN
    chk("wr_ack_en", rsp_en, 1);
    chk("wr_ack_rsp", rsp, 0);
    p0 = rsp_log.size();
    step();
    chk("wr_ack_push", rsp_log.size() - p0, 1);
    chk("wr_ack_off", rsp_en, 0);
    chk("wr_idle", req_rdy, 1);
`else
    chk("wr_no_rsp", rsp_en, 0);
    chk("wr_idle", req_rdy, 1);
`endif

    // 3: backpressure with a second request waiting at the FIFO head
    rsp_rdy = 1'b0;
    fifo.push_back(mk(1'b0, 27'h11, '0));
    fifo.push_back(mk(1'b0, 27'h12, '0));
    drive_head();
    p0 = n_pop;
    pb = rsp_log.size();
    step();
    c = 1;
    while (!rsp_en && c < 40) begin
      step();
      c++;
    end
    chk("bp_lat", c, BEATS + MEM_LAT + 1);
    for (int k = 0; k < 20; k++) begin
      chk("bp_en",   rsp_en, 1);
      chk("bp_data", rsp, L11);
      chk("bp_rdy",  req_rdy, 0);
      step();
    end
    chk("bp_pops", n_pop - p0, 1);
    chk("bp_nopush", rsp_log.size() - pb, 0);
    rsp_rdy = 1'b1;
    p1 = rsp_log.size();
    step();
    chk("bp_push", rsp_log.size() - p1, 1);
    chk("bp_off", rsp_en, 0);
    if (rsp_log.size() > 0) chk("bp_logd", rsp_log[rsp_log.size()-1], L11);
    c = 0;
    while (rsp_log.size() < p1 + 2 && c < 60) begin
      step();
      c++;
    end
    chk("bp_next_cnt", rsp_log.size() - p1, 2);
    if (rsp_log.size() > 0) chk("bp_next_d", rsp_log[rsp_log.size()-1], L12);
    chk("bp_pops2", n_pop - p0, 2);

    // 4: three reads queued back to back
    pb = rsp_log.size();
    p0 = n_pop;
    fifo.push_back(mk(1'b0, 27'h11, '0));
    fifo.push_back(mk(1'b0, 27'h12, '0));
    fifo.push_back(mk(1'b0, 27'h10, '0));
    drive_head();
    c = 0;
    while (rsp_log.size() < pb + 3 && c < 200) begin
      step();
      c++;
    end
    step();
    step();
    chk("b2b_pops", n_pop - p0, 3);
    chk("b2b_fifo", fifo.size(), 0);
    chk("b2b_cnt", rsp_log.size() - pb, 3);
    if (rsp_log.size() >= pb + 3) begin
      chk("b2b_d0", rsp_log[pb],   L11);
      chk("b2b_d1", rsp_log[pb+1], L12);
      chk("b2b_d2", rsp_log[pb+2], L10);
    end

    // 5: reset in cycle 3 of a read, then a clean read
    fifo.push_back(mk(1'b0, 27'h12, '0));
    drive_head();
    step();
    step();
    step();
    chk("mr_men", mem_en, 1);
    rst = 1'b1;
    #1;
    chk_reset_outs("mr");
    step();
    step();
    rst = 1'b0;
    chk_reset_outs("mr_rel");
    run_read(27'h10, L10, "rd5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
